// File: rtl/eth_rx_frame_parser_pkg.sv
// Shared types for the Ethernet RX frame parser: pipe message format, message
// types, header sizes and the parser state encoding.
package eth_rx_frame_parser_pkg;

  typedef enum logic [1:0] {
    rx_none  = 2'd0,
    rx_start = 2'd1,
    rx_data  = 2'd2,
    rx_end   = 2'd3
  } rx_stype;

  localparam logic [7:0] dataPacketType   = 8'h01;
  localparam logic [3:0] ETH_MACHDR_BYTES = 4'd14;
  localparam logic [3:0] ETH_APPHDR_BYTES = 4'd4;

  typedef struct packed {
    logic [7:0]  pid;
    logic [7:0]  ptype;
    logic [15:0] seqnum;
  } eth_rx_hdr_type;

  typedef struct packed {
    eth_rx_hdr_type header;
    logic [31:0]    data;
  } eth_rx_msg_type;

  typedef struct packed {
    rx_stype        stype;
    eth_rx_msg_type msg;
  } eth_rx_pipe_data_type;

  typedef enum logic [2:0] {
    PS_IDLE,
    PS_MACHDR,
    PS_APPHDR,
    PS_PAYLOAD,
    PS_DROP
  } eth_rx_parse_state_type;

endpackage

// File: rtl/eth_rx_frame_parser_if.sv
// MAC byte stream in, RX pipe message out. master = MAC/stimulus side,
// slave = parser side.
interface eth_rx_frame_parser_if;
  import eth_rx_frame_parser_pkg::*;

  logic [7:0]           rx_byte;
  logic                 rx_dv;
  logic                 rx_er;
  logic                 rx_fcs_err;
  eth_rx_pipe_data_type rx_pipe_out;

  modport master (
    output rx_byte, rx_dv, rx_er, rx_fcs_err,
    input  rx_pipe_out
  );

  modport slave (
    input  rx_byte, rx_dv, rx_er, rx_fcs_err,
    output rx_pipe_out
  );
endinterface

// File: rtl/eth_rx_frame_parser_word_packer.sv
// Byte to 32-bit word packer, MSB first. word_o/word_valid_o are combinational
// on the 4th byte so the parser can register the completed word directly.
module eth_rx_word_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic [1:0]  phase_o,
  output logic        word_valid_o
);

  logic [23:0] wbuf_q;
  logic [1:0]  phase_q;

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      wbuf_q  <= '0;
      phase_q <= '0;
    end else if (byte_valid_i) begin
      wbuf_q  <= {wbuf_q[15:0], byte_i};
      phase_q <= phase_q + 2'd1;
    end
  end

  assign word_o       = {wbuf_q, byte_i};
  assign phase_o      = phase_q;
  assign word_valid_o = byte_valid_i && (phase_q == 2'd3);

endmodule

// File: rtl/eth_rx_frame_parser.sv
// Ethernet RX frame parser: strips MAC and app headers, emits rx_start / rx_data /
// rx_end messages. Define ETH_RX_ETYPE_FILTER_EN to drop frames whose ethertype != ETYPE.
module eth_rx_frame_parser
  import eth_rx_frame_parser_pkg::*;
#(
  parameter logic [15:0] ETYPE    = 16'h8888,
  parameter int unsigned MAXWORDS = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  eth_rx_frame_parser_if.slave rx_if,
  output logic [15:0]          frame_cnt,
  output logic [15:0]          drop_cnt
);

  localparam int unsigned   WCW  = $clog2(MAXWORDS + 1);
  localparam logic [WCW-1:0] MAXW = WCW'(MAXWORDS);

  eth_rx_parse_state_type state_q, state_d;
  eth_rx_pipe_data_type   out_q, out_d;
  logic [3:0]             bcnt_q, bcnt_d;
  logic [WCW-1:0]         wcnt_q, wcnt_d;
  logic                   err_q, err_d;
  logic                   ovf_q, ovf_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic [15:0]            drop_cnt_q, drop_cnt_d;
  logic                   dv_prev_q;
`ifdef ETH_RX_ETYPE_FILTER_EN
  logic [7:0]             etype_hi_q, etype_hi_d;
`endif

  logic        pk_clr, pk_valid, pk_word_valid;
  logic [31:0] pk_word;
  logic [1:0]  pk_phase;

  // dv_prev_q follows rx_dv even through reset, so a run already in progress
  // when reset releases is never mistaken for a rising edge.
  assign pk_clr   = (state_q == PS_IDLE) && rx_if.rx_dv && !dv_prev_q;
  assign pk_valid = (state_q == PS_PAYLOAD) && rx_if.rx_dv;

  eth_rx_word_packer u_packer (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (pk_clr),
    .byte_valid_i (pk_valid),
    .byte_i       (rx_if.rx_byte),
    .word_o       (pk_word),
    .phase_o      (pk_phase),
    .word_valid_o (pk_word_valid)
  );

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_d.stype = rx_none;
    bcnt_d      = bcnt_q;
    wcnt_d      = wcnt_q;
    err_d       = err_q;
    ovf_d       = ovf_q;
    frame_cnt_d = frame_cnt_q;
    drop_cnt_d  = drop_cnt_q;
`ifdef ETH_RX_ETYPE_FILTER_EN
    etype_hi_d  = etype_hi_q;
`endif
    case (state_q)
      PS_IDLE: begin
        if (pk_clr) begin
          bcnt_d  = 4'd1;
          state_d = rx_if.rx_er ? PS_DROP : PS_MACHDR;
        end
      end
      PS_MACHDR: begin
        if (!rx_if.rx_dv) begin
          state_d    = PS_IDLE;
          drop_cnt_d = drop_cnt_q + 16'd1;
        end else if (rx_if.rx_er) begin
          state_d = PS_DROP;
        end else begin
          bcnt_d = bcnt_q + 4'd1;
`ifdef ETH_RX_ETYPE_FILTER_EN
          if (bcnt_q == ETH_MACHDR_BYTES - 4'd2) etype_hi_d = rx_if.rx_byte;
`endif
          if (bcnt_q == ETH_MACHDR_BYTES - 4'd1) begin
            bcnt_d  = 4'd0;
            state_d = PS_APPHDR;
`ifdef ETH_RX_ETYPE_FILTER_EN
            if ({etype_hi_q, rx_if.rx_byte} != ETYPE) state_d = PS_DROP;
`endif
          end
        end
      end
      PS_APPHDR: begin
        if (!rx_if.rx_dv) begin
          state_d    = PS_IDLE;
          drop_cnt_d = drop_cnt_q + 16'd1;
        end else if (rx_if.rx_er) begin
          state_d = PS_DROP;
        end else begin
          bcnt_d = bcnt_q + 4'd1;
          case (bcnt_q[1:0])
            2'd0:    out_d.msg.header.pid          = rx_if.rx_byte;
            2'd1:    out_d.msg.header.ptype        = rx_if.rx_byte;
            2'd2:    out_d.msg.header.seqnum[15:8] = rx_if.rx_byte;
            default: out_d.msg.header.seqnum[7:0]  = rx_if.rx_byte;
          endcase
          if (bcnt_q == ETH_APPHDR_BYTES - 4'd1) begin
            out_d.stype    = rx_start;
            out_d.msg.data = '0;
            wcnt_d         = '0;
            err_d          = 1'b0;
            ovf_d          = 1'b0;
            state_d        = PS_PAYLOAD;
          end
        end
      end
      PS_PAYLOAD: begin
        if (rx_if.rx_dv) begin
          if (rx_if.rx_er) err_d = 1'b1;
          if (pk_word_valid) begin
            if (wcnt_q < MAXW) begin
              out_d.stype    = rx_data;
              out_d.msg.data = pk_word;
              wcnt_d         = wcnt_q + 1'b1;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end else begin
          out_d.stype    = rx_end;
          out_d.msg.data = {31'd0, err_q | rx_if.rx_fcs_err | (pk_phase != 2'd0) | ovf_q};
          frame_cnt_d    = frame_cnt_q + 16'd1;
          state_d        = PS_IDLE;
        end
      end
      PS_DROP: begin
        if (!rx_if.rx_dv) begin
          state_d    = PS_IDLE;
          drop_cnt_d = drop_cnt_q + 16'd1;
        end
      end
      default: state_d = PS_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    dv_prev_q <= rx_if.rx_dv;
    if (reset) begin
      state_q     <= PS_IDLE;
      out_q       <= '0;
      bcnt_q      <= '0;
      wcnt_q      <= '0;
      err_q       <= 1'b0;
      ovf_q       <= 1'b0;
      frame_cnt_q <= '0;
      drop_cnt_q  <= '0;
`ifdef ETH_RX_ETYPE_FILTER_EN
      etype_hi_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      bcnt_q      <= bcnt_d;
      wcnt_q      <= wcnt_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      frame_cnt_q <= frame_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
`ifdef ETH_RX_ETYPE_FILTER_EN
      etype_hi_q  <= etype_hi_d;
`endif
    end
  end

  assign rx_if.rx_pipe_out = out_q;
  assign frame_cnt         = frame_cnt_q;
  assign drop_cnt          = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_frame_parser.sv
// Testbench for eth_rx_frame_parser: directed frames plus random bursts, checked
// against a frame-level reference model of the expected message list and counters.
module tb_eth_rx_frame_parser;
  import eth_rx_frame_parser_pkg::*;

  localparam logic [15:0] TB_ETYPE = 16'h8888;
  localparam int          MAXW     = 6;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] frame_cnt, drop_cnt;

  eth_rx_frame_parser_if mac_if ();

  eth_rx_frame_parser #(
    .ETYPE    (TB_ETYPE),
    .MAXWORDS (MAXW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_if     (mac_if),
    .frame_cnt (frame_cnt),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    rx_stype     st;
    logic [31:0] hdr;
    logic [31:0] data;
    int          cyc;
  } msg_t;

  msg_t       exp_q[$];
  msg_t       obs_q[$];
  msg_t       mon_m;
  logic [7:0] frm[$];
  int         drv_cyc[64];
  int         end_cyc;
  int         n_checks = 0;
  int         n_fail = 0;
  int         m_frames = 0;
  int         m_drops = 0;
  bit         filt;

  always @(negedge clk) begin
    if (mac_if.rx_pipe_out.stype != rx_none) begin
      mon_m.st   = mac_if.rx_pipe_out.stype;
      mon_m.hdr  = mac_if.rx_pipe_out.msg.header;
      mon_m.data = mac_if.rx_pipe_out.msg.data;
      mon_m.cyc  = cyc;
      obs_q.push_back(mon_m);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic mk_frame(input logic [15:0] et, input logic [7:0] pid, input logic [7:0] ptype,
                          input logic [15:0] seq, input int plen, input bit rnd);
    frm.delete();
    for (int i = 0; i < 12; i++) frm.push_back(8'($urandom));
    frm.push_back(et[15:8]);
    frm.push_back(et[7:0]);
    frm.push_back(pid);
    frm.push_back(ptype);
    frm.push_back(seq[15:8]);
    frm.push_back(seq[7:0]);
    for (int i = 0; i < plen; i++) frm.push_back(rnd ? 8'($urandom) : 8'(i + 1));
  endtask

  // Expected messages for the frame in frm, derived from byte positions alone.
  task automatic model(input int er_idx, input bit fcs, input int rst_at);
    int          n, eff, p, words;
    bit          drop, err;
    logic [15:0] et;
    msg_t        m;
    n   = frm.size();
    eff = (rst_at >= 0) ? rst_at : n;
    et  = (n >= 14) ? {frm[12], frm[13]} : 16'h0;
    if (rst_at >= 0) begin
      m_frames = 0;
      m_drops  = 0;
    end
    drop = (rst_at < 0) && ((n < 18) || (er_idx >= 0 && er_idx < 18) ||
                            (filt && n >= 14 && et != TB_ETYPE));
    if (drop) begin
      m_drops++;
    end else if (eff >= 18) begin
      m.hdr  = {frm[14], frm[15], frm[16], frm[17]};
      m.st   = rx_start;
      m.data = '0;
      m.cyc  = drv_cyc[17] + 1;
      exp_q.push_back(m);
      p     = eff - 18;
      words = p / 4;
      for (int k = 0; k < words && k < MAXW; k++) begin
        m.st   = rx_data;
        m.data = {frm[18+4*k], frm[19+4*k], frm[20+4*k], frm[21+4*k]};
        m.cyc  = drv_cyc[21+4*k] + 1;
        exp_q.push_back(m);
      end
      if (rst_at < 0) begin
        err    = (er_idx >= 18) || fcs || (p % 4 != 0) || (words > MAXW);
        m.st   = rx_end;
        m.data = {31'd0, err};
        m.cyc  = end_cyc + 1;
        exp_q.push_back(m);
        m_frames++;
      end
    end
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk); #1;
      mac_if.rx_dv      = 1'b0;
      mac_if.rx_er      = 1'b0;
      mac_if.rx_fcs_err = 1'b0;
    end
  endtask

  task automatic send(input int er_idx, input bit fcs, input int rst_at, input int gap);
    for (int i = 0; i < frm.size(); i++) begin
      @(posedge clk); #1;
      mac_if.rx_byte    = frm[i];
      mac_if.rx_dv      = 1'b1;
      mac_if.rx_er      = (i == er_idx);
      mac_if.rx_fcs_err = 1'b0;
      reset             = (rst_at >= 0) && (i == rst_at || i == rst_at + 1);
      drv_cyc[i]        = cyc;
    end
    @(posedge clk); #1;
    mac_if.rx_byte    = '0;
    mac_if.rx_dv      = 1'b0;
    mac_if.rx_er      = 1'b0;
    mac_if.rx_fcs_err = fcs;
    reset             = 1'b0;
    end_cyc           = cyc;
    idle(gap);
    model(er_idx, fcs, rst_at);
  endtask

  task automatic flush(input string tag);
    int nn;
    check_eq({tag, ".nmsg"}, obs_q.size(), exp_q.size());
    nn = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < nn; i++) begin
      check_eq($sformatf("%s[%0d].stype", tag, i), obs_q[i].st, exp_q[i].st);
      check_eq($sformatf("%s[%0d].hdr", tag, i), obs_q[i].hdr, exp_q[i].hdr);
      check_eq($sformatf("%s[%0d].cyc", tag, i), obs_q[i].cyc, exp_q[i].cyc);
      if (exp_q[i].st != rx_start)
        check_eq($sformatf("%s[%0d].data", tag, i), obs_q[i].data, exp_q[i].data);
    end
    check_eq({tag, ".frame_cnt"}, frame_cnt, 16'(m_frames));
    check_eq({tag, ".drop_cnt"}, drop_cnt, 16'(m_drops));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end

  initial begin
    int plen, er, gap;
    logic [15:0] et;
`ifdef ETH_RX_ETYPE_FILTER_EN
    filt = 1'b1;
`else
    filt = 1'b0;
`endif
    mac_if.rx_byte    = '0;
    mac_if.rx_dv      = 1'b0;
    mac_if.rx_er      = 1'b0;
    mac_if.rx_fcs_err = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst.stype", mac_if.rx_pipe_out.stype, rx_none);
    check_eq("rst.frame_cnt", frame_cnt, 16'd0);
    check_eq("rst.drop_cnt", drop_cnt, 16'd0);

    mk_frame(TB_ETYPE, 8'h03, dataPacketType, 16'h0102, 8, 1'b0);
    send(-1, 1'b0, -1, 2);
    idle(3);
    check_eq("t1.frame_cnt_is_1", frame_cnt, 16'd1);
    flush("t1_good");

    send(-1, 1'b1, -1, 2);
    idle(3);
    flush("t2_fcs");

    mk_frame(TB_ETYPE, 8'h03, dataPacketType, 16'h0102, 6, 1'b0);
    send(-1, 1'b0, -1, 2);
    idle(3);
    flush("t3_partial");

    mk_frame(TB_ETYPE, 8'h11, dataPacketType, 16'h0304, 8, 1'b0);
    while (frm.size() > 10) void'(frm.pop_back());
    send(-1, 1'b0, -1, 0);
    mk_frame(TB_ETYPE, 8'h12, dataPacketType, 16'h0506, 8, 1'b0);
    send(-1, 1'b0, -1, 2);
    idle(3);
    flush("t4_short");

    mk_frame(16'h0800, 8'h21, dataPacketType, 16'h0708, 8, 1'b0);
    send(-1, 1'b0, -1, 2);
    idle(3);
    flush("t5_etype");

    mk_frame(TB_ETYPE, 8'h31, dataPacketType, 16'h0900, 4 * MAXW, 1'b0);
    send(-1, 1'b0, -1, 0);
    mk_frame(TB_ETYPE, 8'h32, dataPacketType, 16'h0901, 4 * MAXW + 4, 1'b0);
    send(-1, 1'b0, -1, 0);
    mk_frame(TB_ETYPE, 8'h33, dataPacketType, 16'h0902, 0, 1'b0);
    send(-1, 1'b0, -1, 2);
    idle(3);
    flush("t_maxwords");

    mk_frame(TB_ETYPE, 8'h41, dataPacketType, 16'h0A0B, 16, 1'b0);
    send(-1, 1'b0, 24, 2);
    mk_frame(TB_ETYPE, 8'h42, dataPacketType, 16'h0C0D, 4, 1'b0);
    send(-1, 1'b0, -1, 2);
    idle(3);
    flush("t6_reset");

    for (int b = 0; b < 25; b++) begin
      for (int f = 0; f < 4; f++) begin
        plen = $urandom_range(0, 30);
        et   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : TB_ETYPE;
        mk_frame(et, 8'($urandom), 8'($urandom), 16'($urandom), plen, 1'b1);
        if ($urandom_range(0, 7) == 0) begin
          plen = $urandom_range(1, 17);
          while (frm.size() > plen) void'(frm.pop_back());
        end
        er  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, frm.size() - 1) : -1;
        gap = $urandom_range(0, 2);
        send(er, ($urandom_range(0, 5) == 0), -1, gap);
      end
      idle(3);
      flush($sformatf("rnd%0d", b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
